// File: rtl/shift_add_mult4_pkg.sv
// ============================================================================
// Module      : shift_add_mult4_pkg
// Description : Shared constants and FSM state encoding for the 4x4 multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_add_mult4_pkg;

    localparam int OPW  = 4;
    localparam int ITER = 4;
    localparam int PW   = 2 * OPW;
    localparam int CNTW = $clog2(ITER);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/add4_ripple.sv
// ============================================================================
// Module      : add4_ripple
// Description : Purely combinational 4-bit ripple-carry adder of full-adder cells.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module add4_ripple (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] w_carry;

    assign w_carry[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign sum[i]       = x[i] ^ y[i] ^ w_carry[i];
        assign w_carry[i+1] = (x[i] & y[i]) | (w_carry[i] & (x[i] ^ y[i]));
    end

    assign cout = w_carry[4];

endmodule

`default_nettype wire

// File: rtl/shift_add_mult4.sv
// ============================================================================
// Module      : shift_add_mult4
// Description : Sequential 4x4 unsigned shift-and-add multiplier (accept, 4 RUN, DONE).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_add_mult4
    import shift_add_mult4_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [OPW-1:0] a,
    input  logic [OPW-1:0] b,
    output logic          busy,
    output logic          done,
    output logic [PW-1:0] product
);

    localparam logic [CNTW-1:0] c_last_iter = CNTW'(ITER - 1);

    state_t          r_state;
    logic [OPW-1:0]  r_m;
    logic [OPW-1:0]  r_q;
    logic [OPW:0]    r_acc;
    logic [CNTW-1:0] r_cnt;
    logic [PW-1:0]   r_product;
    logic            r_busy;
    logic            r_done;

    logic [OPW-1:0]  w_add_sum;
    logic            w_add_cout;
    logic [OPW:0]    w_sum;
    logic [OPW-1:0]  w_a_next;
    logic [OPW-1:0]  w_q_next;

    add4_ripple u_add (
        .x    (r_acc[OPW-1:0]),
        .y    (r_m),
        .cin  (1'b0),
        .sum  (w_add_sum),
        .cout (w_add_cout)
    );

    // C is always zero after a shift, so r_acc doubles as the zero-extended A.
    assign w_sum    = r_q[0] ? {w_add_cout, w_add_sum} : r_acc;
    assign w_a_next = w_sum[OPW:1];
    assign w_q_next = {w_sum[0], r_q[OPW-1:1]};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= IDLE;
            r_m       <= '0;
            r_q       <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_product <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_m     <= a;
                        r_q     <= b;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_acc <= {1'b0, w_a_next};
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt + CNTW'(1);
                    if (r_cnt == c_last_iter) begin
                        r_product <= {w_a_next, w_q_next};
                        r_done    <= 1'b1;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_product;

endmodule

`default_nettype wire

// File: tb/tb_shift_add_mult4.sv
// ============================================================================
// Module      : tb_shift_add_mult4
// Description : Scoreboard bench for the 4x4 shift-and-add multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_add_mult4;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [7:0] product;

    int         n_checks = 0;
    int         n_errors = 0;
    int         n_done   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] hold_exp = 8'h00;

    always #5 clock = ~clock;

    shift_add_mult4 dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    task automatic check_value(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (done === 1'b1) begin
            n_done++;
            if (exp_q.size() == 0) begin
                check_value("unexpected_done", 16'd1, 16'd0);
            end else begin
                hold_exp = exp_q[0];
                check_value("product", {8'h00, product}, {8'h00, exp_q[0]});
                void'(exp_q.pop_front());
            end
        end
    end

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic run_op(input logic [3:0] ta, input logic [3:0] tb, input bit noise);
        int cyc;
        check_value("idle_before", {15'd0, busy}, 16'd0);
        a = ta;
        b = tb;
        start = 1'b1;
        exp_q.push_back(8'(ta) * 8'(tb));
        @(negedge clock);
        start = 1'b0;
        a = 4'($urandom);
        b = 4'($urandom);
        check_value("busy_after_accept", {15'd0, busy}, 16'd1);
        check_value("done_after_accept", {15'd0, done}, 16'd0);
        cyc = 0;
        while (done !== 1'b1 && cyc < 12) begin
            check_value("product_hold", {8'h00, product}, {8'h00, hold_exp});
            if (noise) begin
                start = (cyc < 3);
                a = 4'd7;
                b = 4'd7;
            end
            @(negedge clock);
            cyc++;
        end
        start = 1'b0;
        check_value("latency", 16'(cyc), 16'd4);
        @(negedge clock);
        check_value("done_single", {15'd0, done}, 16'd0);
        check_value("busy_idle", {15'd0, busy}, 16'd0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int cyc;
        int low;
        int dones_before;

        // Reset held with start high: reset must win.
        reset = 1'b1;
        start = 1'b1;
        a = 4'd5;
        b = 4'd5;
        repeat (3) @(negedge clock);
        check_value("rst_busy", {15'd0, busy}, 16'd0);
        check_value("rst_done", {15'd0, done}, 16'd0);
        check_value("rst_product", {8'h00, product}, 16'h0000);
        reset = 1'b0;
        start = 1'b0;

        // First start is accepted on the first edge after reset releases.
        run_op(4'd13, 4'd11, 1'b0);
        run_op(4'd15, 4'd15, 1'b0);
        run_op(4'd0, 4'd9, 1'b0);

        // Start pulses during RUN are ignored.
        dones_before = n_done;
        run_op(4'd3, 4'd5, 1'b1);
        check_value("single_done", 16'(n_done - dones_before), 16'd1);
        run_op(4'd6, 4'd4, 1'b0);

        // Start held high: ops every 6 cycles with one idle cycle between.
        a = 4'd2;
        b = 4'd6;
        start = 1'b1;
        repeat (3) exp_q.push_back(8'h0C);
        for (int op = 0; op < 3; op++) begin
            cyc = 0;
            low = 0;
            do begin
                @(negedge clock);
                cyc++;
                if (busy !== 1'b1) low++;
            end while (done !== 1'b1 && cyc < 20);
            check_value("held_period", 16'(cyc), (op == 0) ? 16'd5 : 16'd6);
            check_value("held_idle_gap", 16'(low), (op == 0) ? 16'd0 : 16'd1);
        end
        start = 1'b0;
        @(negedge clock);
        check_value("held_stop_busy", {15'd0, busy}, 16'd0);

        // Reset on the 2nd RUN edge aborts with no done pulse.
        dones_before = n_done;
        a = 4'd9;
        b = 4'd9;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check_value("abort_busy_run", {15'd0, busy}, 16'd1);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        hold_exp = 8'h00;
        check_value("abort_busy", {15'd0, busy}, 16'd0);
        check_value("abort_done", {15'd0, done}, 16'd0);
        check_value("abort_product", {8'h00, product}, 16'h0000);
        repeat (6) @(negedge clock);
        check_value("abort_no_done", 16'(n_done - dones_before), 16'd0);
        run_op(4'd1, 4'd1, 1'b0);

        // Exhaustive sweep against the reference multiply.
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                run_op(4'(ai), 4'(bi), 1'b0);
            end
        end

        check_value("queue_empty", 16'(exp_q.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/shift_add_mult4.md
SHIFT_ADD_MULT4 -- requirements
Module: shift_add_mult4

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 4 bits and product width at 8 bits.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a multiply; sampled only in IDLE.
REQ-005 a  input  4  multiplicand, unsigned; sampled on the accept edge.
REQ-006 b  input  4  multiplier, unsigned; sampled on the accept edge.
REQ-007 busy  output  1  high in RUN and DONE.
REQ-008 done  output  1  single-cycle pulse; product valid.
REQ-009 product  output  8  unsigned a*b; registered.

Function
REQ-010 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-011 Accept edge: on a rising edge in IDLE with start=1, the block SHALL do all of the following.
- Load M<=a and Q<=b.
- Clear the 5-bit accumulator {C,A} to 0.
- Clear the 2-bit iteration counter.
- Enter RUN.
REQ-012 Each RUN edge SHALL perform one add-and-shift iteration.
- sum = Q[0] ? A+M (5-bit result incl. carry) : {0,A}.
- Then {C,A,Q} <= {0,sum,Q} >> 1.
- Counter increments by 1.
REQ-013 The add SHALL use the sub-module's 4-bit ripple sum; its carry-out is the 5th bit of sum, and no bit is lost before the shift.
REQ-014 On the RUN edge where the counter equals 3 (fourth iteration), the block SHALL do all of the following.
- Load product with the post-shift {A,Q}.
- Enter DONE.
REQ-015 Latency: done SHALL be high for exactly one cycle, starting 4 edges after the accept edge; the next edge returns to IDLE.
REQ-016 product SHALL hold its value from the DONE-entry edge until the next completion or reset; it is never partially updated during RUN.
REQ-017 start SHALL be ignored in RUN and DONE (no queuing); start held high continuously yields back-to-back ops every 6 cycles (accept, 4 RUN, DONE).
REQ-018 a and b SHALL be don't-care after the accept edge; changes during RUN do not affect the result.
REQ-019 Boundary values SHALL produce exact results with no overflow: 0*x=0 and 15*15=225 (8'hE1).
REQ-020 busy SHALL be low in IDLE and high in RUN and DONE; done SHALL be high only in DONE.

Reset
REQ-021 With reset=1 at a rising edge, the block SHALL set the following, regardless of state.
- State IDLE.
- busy=0, done=0, product=8'h00.
- M, Q, {C,A} and counter all 0.
REQ-022 Reset SHALL take priority over start on the same edge, and a reset mid-RUN SHALL abort the operation with no done pulse.
REQ-023 The first start can be accepted on the first edge after reset deasserts.

Structure
REQ-024 A shared package SHALL hold the FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the constants OPW=4 and ITER=4.
REQ-025 One sub-module, add4_ripple, SHALL implement the datapath adder.
- Ports: x[3:0], y[3:0], cin, sum[3:0], cout.
- Built as a chain of four full-adder bit cells.
- Instantiated once with cin tied to 0.
REQ-026 Only the FSM, counter and M/Q/{C,A}/product registers SHALL be sequential; add4_ripple SHALL be purely combinational.

Verification
REQ-027 The bench SHALL cover the following directed scenarios.
- a=13, b=11, start pulse -> busy=1 next cycle; done pulse 4 edges after accept; product=8'h8F (143).
- a=15, b=15 -> product=8'hE1 (exercises carry into C every iteration); a=0, b=9 -> product=8'h00.
- a=3, b=5 accepted; during RUN, start=1 with a=7, b=7 -> ignored; product=8'h0F, a single done pulse; next op still runs normally.
- start held high with a=2, b=6 -> done pulses every 6 cycles; product=8'h0C each time; busy low exactly one cycle between ops.
- a=9, b=9; reset asserted on the 2nd RUN edge -> IDLE, busy=0, no done, product=8'h00; a following op with a=1, b=1 -> product=8'h01.
- Exhaustive sweep of all 256 (a,b) pairs -> product equals a*b each time, checked against a reference model.
